// File: rtl/piso_frame_tx_if.sv
// piso_frame_tx_if
// Word-input handshake of the frame transmitter.
//   i        [0:WIDTH-1]  parallel word, i[0] is sent first
//   i_valid  1            upstream holds a word in i
//   i_ready  1            transmitter can take a word this cycle
// Handshake: a word transfers on a falling clk edge where i_valid and
// i_ready are both 1. Once i_valid rises, upstream must hold i and i_valid
// unchanged until that transfer; i_ready may be low for any number of
// cycles before it happens.
interface piso_frame_tx_if #(
    parameter int WIDTH = 4
);
    logic [0:WIDTH-1] i;
    logic             i_valid;
    logic             i_ready;

    modport master (output i, output i_valid, input  i_ready);
    modport slave  (input  i, input  i_valid, output i_ready);
endinterface

// File: rtl/piso_frame_tx.sv
// piso_frame_tx
// Parallel-in serial-out frame transmitter for the 1-wire serial link.
// Each word is sent as: start bit (0), data bits i[0]..i[WIDTH-1],
// optional even-parity bit, stop bit (1). All state changes on negedge clk.
// Ports:
//   clk        clock, registers update on the falling edge
//   rst_n      synchronous active-low reset, sampled on the falling edge
//   up         word handshake (slave side of piso_frame_tx_if)
//   so         serial line, idles high
//   busy       frame in progress (START through STOP)
//   done       one-cycle pulse during the stop bit
//   dbg_state  current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
module piso_frame_tx #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_frame_tx_if.slave   up,
    output logic             so,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Counter only needs to reach WIDTH-1, so it never wraps inside a frame.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [0:WIDTH-1] sh;
    logic             par;
    logic [CW-1:0]    cnt;

    // STOP also accepts, which is what lets frames run back to back.
    assign up.i_ready = rst_n && ((state == IDLE) || (state == STOP));
    assign dbg_state  = state;

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            so    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            sh    <= '0;
            par   <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, STOP: begin
                    if (up.i_valid) begin
                        // Shadow copy: later changes on i cannot reach the frame.
                        sh    <= up.i;
                        par   <= ^up.i;
                        state <= START;
                        so    <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        so    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                START: begin
                    state <= DATA;
                    so    <= sh[0];
                    sh    <= {sh[1:WIDTH-1], 1'b0};
                    cnt   <= '0;
                end
                DATA: begin
                    // cnt is the index of the bit currently on so.
                    if (cnt == LAST) begin
                        if (PARITY_EN) begin
                            state <= PARITY;
                            so    <= par;
                        end else begin
                            state <= STOP;
                            so    <= 1'b1;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        so  <= sh[0];
                        sh  <= {sh[1:WIDTH-1], 1'b0};
                    end
                end
                PARITY: begin
                    state <= STOP;
                    so    <= 1'b1;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    so    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_frame_tx.sv
// tb_piso_frame_tx
// Two transmitters share clk and rst_n: dut_p (WIDTH=4, parity) and
// dut_n (WIDTH=4, no parity). The DUTs act on negedge; the bench drives
// and samples 1 time unit after posedge.
module tb_piso_frame_tx;
    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    piso_frame_tx_if #(.WIDTH(W)) bus_p ();
    piso_frame_tx_if #(.WIDTH(W)) bus_n ();

    logic       so_p, busy_p, done_p;
    logic       so_n, busy_n, done_n;
    logic [2:0] st_p, st_n;

    piso_frame_tx #(.WIDTH(W), .PARITY_EN(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n), .up(bus_p),
        .so(so_p), .busy(busy_p), .done(done_p), .dbg_state(st_p)
    );

    piso_frame_tx #(.WIDTH(W), .PARITY_EN(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .up(bus_n),
        .so(so_n), .busy(busy_n), .done(done_n), .dbg_state(st_n)
    );

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [0:0] exp_q[$];
    bit         last_q[$];

    // Reference frame: start 0, data in order, even parity, stop 1.
    function automatic void push_frame(input logic [0:W-1] w, input bit pen);
        exp_q.push_back(1'b0);
        last_q.push_back(1'b0);
        for (int k = 0; k < W; k++) begin
            exp_q.push_back(w[k]);
            last_q.push_back(1'b0);
        end
        if (pen) begin
            exp_q.push_back(1'($countones(w) % 2));
            last_q.push_back(1'b0);
        end
        exp_q.push_back(1'b1);
        last_q.push_back(1'b1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus_p.i = '0; bus_p.i_valid = 1'b0;
        bus_n.i = '0; bus_n.i_valid = 1'b0;
        repeat (3) cyc();
        n_tests++;
        if (so_p !== 1'b1 || busy_p !== 1'b0 || done_p !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_p: so/busy/done got %b%b%b expected 100", so_p, busy_p, done_p);
        end
        n_tests++;
        if (so_n !== 1'b1 || busy_n !== 1'b0 || done_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_n: so/busy/done got %b%b%b expected 100", so_n, busy_n, done_n);
        end
        rst_n = 1'b1;
        cyc();
        n_tests++;
        if (bus_p.i_ready !== 1'b1 || bus_n.i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b%b expected 11", bus_p.i_ready, bus_n.i_ready);
        end
        for (int c = 0; c < 5; c++) begin
            cyc();
            n_tests++;
            if (so_p !== 1'b1 || busy_p !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: so/busy got %b%b expected 10", c, so_p, busy_p);
            end
        end
    endtask

    task automatic test_single_frame(input logic [0:W-1] w);
        logic [0:0] e;
        bit         l;
        int         b = 0;
        exp_q.delete();
        last_q.delete();
        push_frame(w, 1'b1);
        n_tests++;
        if (busy_p !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pre_busy: got %b expected 0", busy_p);
        end
        bus_p.i = w;
        bus_p.i_valid = 1'b1;
        while (exp_q.size() > 0) begin
            cyc();
            bus_p.i_valid = 1'b0;
            e = exp_q.pop_front();
            l = last_q.pop_front();
            n_tests++;
            if (so_p !== e || done_p !== l || busy_p !== 1'b1 || bus_p.i_ready !== l) begin
                n_fail++;
                $display("FAIL single w=%b bit%0d: so/done/busy/ready got %b%b%b%b expected %b%b1%b",
                         w, b, so_p, done_p, busy_p, bus_p.i_ready, e, l, l);
            end
            b++;
        end
        cyc();
        n_tests++;
        if (so_p !== 1'b1 || busy_p !== 1'b0 || done_p !== 1'b0 || bus_p.i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle w=%b: so/busy/done/ready got %b%b%b%b expected 1001",
                     w, so_p, busy_p, done_p, bus_p.i_ready);
        end
    endtask

    task automatic test_input_stability(input logic [0:W-1] w);
        logic [0:0] e;
        bit         l;
        int         b = 0;
        exp_q.delete();
        last_q.delete();
        push_frame(w, 1'b1);
        bus_p.i = w;
        bus_p.i_valid = 1'b1;
        while (exp_q.size() > 0) begin
            cyc();
            bus_p.i_valid = 1'b0;
            bus_p.i = W'($urandom_range(0, (1 << W) - 1));
            e = exp_q.pop_front();
            l = last_q.pop_front();
            n_tests++;
            if (so_p !== e || done_p !== l) begin
                n_fail++;
                $display("FAIL stability w=%b bit%0d: so/done got %b%b expected %b%b",
                         w, b, so_p, done_p, e, l);
            end
            b++;
        end
        cyc();
    endtask

    task automatic test_back_to_back(input logic [0:W-1] w0, input logic [0:W-1] w1,
                                     input logic [0:W-1] w2);
        logic [0:W-1] words[3];
        logic [0:0]   e;
        bit           l;
        int           k = 0;
        int           dones = 0;
        int           len = W + 3;
        words[0] = w0; words[1] = w1; words[2] = w2;
        exp_q.delete();
        last_q.delete();
        for (int f = 0; f < 3; f++) push_frame(words[f], 1'b1);
        bus_p.i = words[0];
        bus_p.i_valid = 1'b1;
        for (int c = 0; c < 3 * len; c++) begin
            cyc();
            // A start bit on so means the held word was just taken.
            if (c % len == 0) begin
                k++;
                if (k < 3) bus_p.i = words[k];
                else bus_p.i_valid = 1'b0;
            end
            e = exp_q.pop_front();
            l = last_q.pop_front();
            if (done_p === 1'b1) dones++;
            n_tests++;
            if (so_p !== e || done_p !== l || busy_p !== 1'b1 || bus_p.i_ready !== l) begin
                n_fail++;
                $display("FAIL b2b c%0d: so/done/busy/ready got %b%b%b%b expected %b%b1%b",
                         c, so_p, done_p, busy_p, bus_p.i_ready, e, l, l);
            end
        end
        cyc();
        n_tests++;
        if (dones !== 3 || so_p !== 1'b1 || busy_p !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: dones/so/busy got %0d/%b/%b expected 3/1/0", dones, so_p, busy_p);
        end
    endtask

    task automatic test_reset_mid_frame(input logic [0:W-1] w);
        logic [0:0] e;
        exp_q.delete();
        last_q.delete();
        push_frame(w, 1'b1);
        bus_p.i = w;
        bus_p.i_valid = 1'b1;
        // Observe start, d0, d1, d2; reset lands on the following edge.
        for (int c = 0; c < 4; c++) begin
            cyc();
            bus_p.i_valid = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if (so_p !== e || done_p !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_pre c%0d: so/done got %b%b expected %b0", c, so_p, done_p, e);
            end
        end
        rst_n = 1'b0;
        cyc();
        n_tests++;
        if (so_p !== 1'b1 || busy_p !== 1'b0 || done_p !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abort: so/busy/done got %b%b%b expected 100", so_p, busy_p, done_p);
        end
        rst_n = 1'b1;
        cyc();
        n_tests++;
        if (so_p !== 1'b1 || done_p !== 1'b0 || bus_p.i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_release: so/done/ready got %b%b%b expected 101",
                     so_p, done_p, bus_p.i_ready);
        end
        test_single_frame(W'($urandom_range(0, (1 << W) - 1)));
    endtask

    task automatic test_no_parity(input logic [0:W-1] w);
        logic [0:0] e;
        bit         l;
        int         b = 0;
        exp_q.delete();
        last_q.delete();
        push_frame(w, 1'b0);
        n_tests++;
        if (exp_q.size() != W + 2) begin
            n_fail++;
            $display("FAIL noparity_len: model frame %0d expected %0d", exp_q.size(), W + 2);
        end
        bus_n.i = w;
        bus_n.i_valid = 1'b1;
        while (exp_q.size() > 0) begin
            cyc();
            bus_n.i_valid = 1'b0;
            e = exp_q.pop_front();
            l = last_q.pop_front();
            n_tests++;
            if (so_n !== e || done_n !== l || busy_n !== 1'b1) begin
                n_fail++;
                $display("FAIL noparity w=%b bit%0d: so/done/busy got %b%b%b expected %b%b1",
                         w, b, so_n, done_n, busy_n, e, l);
            end
            b++;
        end
        cyc();
        n_tests++;
        if (so_n !== 1'b1 || busy_n !== 1'b0 || done_n !== 1'b0) begin
            n_fail++;
            $display("FAIL noparity_idle: so/busy/done got %b%b%b expected 100", so_n, busy_n, done_n);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_frame(4'b1001);
        test_single_frame(4'b1011);
        for (int r = 0; r < 4; r++) test_single_frame(W'($urandom_range(0, (1 << W) - 1)));
        test_input_stability(4'b0110);
        test_input_stability(W'($urandom_range(0, (1 << W) - 1)));
        test_back_to_back(4'b1001, 4'b1010, 4'b1111);
        test_back_to_back(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                          W'($urandom_range(0, 15)));
        test_reset_mid_frame(W'($urandom_range(0, (1 << W) - 1)));
        test_no_parity(4'b1001);
        test_no_parity(W'($urandom_range(0, (1 << W) - 1)));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
